reg_mem_responder: RTL and testbench
====================================

Name: reg_mem_responder

Overview:
- Device-side endpoint of the register interface: a small word-addressed register memory that terminates reg requests and generates responses.
- Honours byte strobes and inserts a configurable number of wait states via an internal counter.
- Flags decode errors for misaligned or out-of-range accesses.
- Used as a scratch register bank and as the reference responder behind request filters in the register-bus test environments.

Parameters:
- AddrWidth, 32, width of req.addr
- DataWidth, 32, width of req.wdata/rsp.rdata; multiple of 8
- NumWords, 16, number of DataWidth-bit storage words; >= 1
- BaseAddr, 0, byte address of word 0; aligned to DataWidth/8
- Latency, 1, wait cycles before ready; 0..255
- req_t, logic, reg request struct {addr, write, wdata, wstrb, valid}
- rsp_t, logic, reg response struct {rdata, error, ready}

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- reg_req_i  input  $bits(req_t)  incoming register request
- reg_rsp_o  output  $bits(rsp_t)  register response

Behaviour:
- Reset: clk_i single clock; rst_i synchronous active-high. Storage words <= '0, FSM <= IDLE, counter <= 0. reg_rsp_o.ready=0, error=0, rdata='0 during and after reset until a request is served.
- Protocol:
  - Request is held stable while valid=1 until the cycle with ready=1.
  - Transfer completes in the cycle where valid=1 and ready=1.
  - ready is never asserted while valid=0.
- Decode:
  - off = addr - BaseAddr (AddrWidth-bit unsigned, wraps).
  - Error if off[log2(DataWidth/8)-1:0] != 0 or off >> log2(DataWidth/8) >= NumWords.
  - Otherwise idx = off >> log2(DataWidth/8).
- Latency==0: no FSM. ready = valid, combinational from the request, so one transfer per cycle.
- Latency>=1, FSM IDLE/WAIT:
  - IDLE with valid=1: load counter = Latency-1, go to WAIT. ready=0.
  - WAIT with counter != 0: decrement counter. ready=0.
  - WAIT with counter == 0: ready=1 combinationally, return to IDLE.
  - ready therefore first asserts Latency cycles after the first valid cycle.
  - Back-to-back requests: the next request's valid cycle after a completion is treated as a new IDLE entry. Throughput is one transfer per Latency+1 cycles.
- WAIT with valid dropped (protocol violation): return to IDLE, counter cleared, no write, no response.
- Response contents (only meaningful while ready=1; drive '0 otherwise):
  - Read, no error: rdata = mem[idx], error=0.
  - Write: rdata='0.
  - Decode error, read or write: error=1, rdata='0, no storage change.
- Write commit in the completion cycle, on the clock edge:
  - For each byte b with wstrb[b]=1: mem[idx][8b+7:8b] <= wdata[8b+7:8b].
  - Bytes with wstrb[b]=0 are unchanged.
  - wstrb=='0 completes normally with error=0 and no change. Empty writes are legal at this endpoint.
- Read of a word written in the same cycle is impossible: one outstanding transfer.
- A read completing in the cycle after a write returns the updated value.
- Reset asserted mid-WAIT: FSM returns to IDLE the next edge, pending write dropped, storage cleared. A still-held request restarts its full latency after reset deasserts.
- Boundaries:
  - Last word (idx=NumWords-1) is valid.
  - NumWords*DataWidth/8 offset is an error.
  - Addresses below BaseAddr wrap to a large offset and error.

Test Plan:
- Reset then read addr 0x0 (defaults) -> ready high exactly 1 cycle after valid, rdata=0x00000000, error=0.
- Write 0x0C wdata=0xDEADBEEF wstrb=0xF, then write 0x0C wdata=0x11223344 wstrb=0x5, read 0x0C -> rdata=0xDE22BE44.
- Write 0x08 wdata=0xFFFFFFFF wstrb=0x0 -> ready, error=0. Subsequent read 0x08 -> 0x00000000.
- Read 0x40 (NumWords=16) and read 0x06 (misaligned) -> error=1, rdata=0. Write 0x40 -> error=1, no word modified (scan all 16 = 0).
- Latency=3: valid held at cycle t -> ready only at t+3. Valid dropped at t+1 -> no ready, no write. Latency=0: 4 back-to-back writes in 4 cycles, all committed.
- Assert rst_i at t+1 of a Latency=3 write to 0x04 after preloading 0x04=0xA5A5A5A5 -> word 0x04 reads 0x00000000, no spurious ready during reset.

Source files
------------

// File: rtl/reg_mem_responder.sv
// rtl/reg_mem_responder.sv - word-addressed register memory that terminates reg requests
module reg_mem_responder #(
    parameter int                   AddrWidth = 32,
    parameter int                   DataWidth = 32,
    parameter int                   NumWords  = 16,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int                   Latency   = 1,
    localparam int                  StrbWidth = DataWidth / 8,
    localparam int                  ReqWidth  = AddrWidth + 1 + DataWidth + StrbWidth + 1,
    localparam int                  RspWidth  = DataWidth + 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ReqWidth-1:0] reg_req_i,
    output logic [RspWidth-1:0] reg_rsp_o
);
    localparam int OffBits  = $clog2(StrbWidth);
    localparam int IdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(StrbWidth - 1);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
        logic                 valid;
    } req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } rsp_t;

    req_t                 w_req;
    rsp_t                 w_rsp;
    logic [AddrWidth-1:0] w_off;
    logic [AddrWidth-1:0] w_word;
    logic [IdxWidth-1:0]  w_idx;
    logic                 w_err;
    logic                 w_ready_raw;
    logic                 w_ready;
    logic [DataWidth-1:0] r_mem [NumWords];

    assign w_req  = reg_req_i;
    // Addresses below BaseAddr wrap to a huge offset and fall out of range.
    assign w_off  = w_req.addr - BaseAddr;
    assign w_word = w_off >> OffBits;
    assign w_idx  = w_word[IdxWidth-1:0];
    assign w_err  = (|(w_off & OffMask)) || (w_word >= AddrWidth'(NumWords));

    generate
        if (Latency == 0) begin : g_comb
            assign w_ready_raw = w_req.valid;
        end else begin : g_fsm
            typedef enum logic {S_IDLE, S_WAIT} state_t;
            state_t     r_state;
            state_t     w_state_next;
            logic [7:0] r_cnt;
            logic [7:0] w_cnt_next;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_ready_raw  = 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_req.valid) begin
                            w_cnt_next   = 8'(Latency - 1);
                            w_state_next = S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (!w_req.valid) begin
                            w_cnt_next   = '0;
                            w_state_next = S_IDLE;
                        end else if (r_cnt != '0) begin
                            w_cnt_next = r_cnt - 8'd1;
                        end else begin
                            w_ready_raw  = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end
                    default: w_state_next = S_IDLE;
                endcase
            end
        end
    endgenerate

    // A completion can never be signalled while the block is held in reset.
    assign w_ready = w_ready_raw & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_ready && w_req.write && !w_err) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (w_req.wstrb[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_req.wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rsp       = '0;
        w_rsp.ready = w_ready;
        w_rsp.error = w_ready && w_err;
        if (w_ready && !w_err && !w_req.write) begin
            w_rsp.rdata = r_mem[w_idx];
        end
    end

    assign reg_rsp_o = w_rsp;
endmodule

// File: tb/tb_reg_mem_responder.sv
// tb/tb_reg_mem_responder.sv - scoreboard bench for reg_mem_responder at latencies 0, 1 and 3
module tb_reg_mem_responder;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int RQW = AW + 1 + DW + SW + 1;
    localparam int RSW = DW + 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst [3];
    logic [RQW-1:0] req [3];
    logic [RSW-1:0] rsp [3];
    int             lat_cnt [3];
    int             n_chk  = 0;
    int             n_fail = 0;
    int             cyc    = 0;
    exp_t           q0[$];
    exp_t           q1[$];
    exp_t           q3[$];
    logic [31:0]    scan_exp [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_mem_responder #(.BaseAddr(32'h100), .Latency(0)) u_l0 (
        .clk_i(clk), .rst_i(rst[0]), .reg_req_i(req[0]), .reg_rsp_o(rsp[0]));
    reg_mem_responder #(.Latency(1)) u_l1 (
        .clk_i(clk), .rst_i(rst[1]), .reg_req_i(req[1]), .reg_rsp_o(rsp[1]));
    reg_mem_responder #(.Latency(3)) u_l3 (
        .clk_i(clk), .rst_i(rst[2]), .reg_req_i(req[2]), .reg_rsp_o(rsp[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h required %h", name, d, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each completion and tracks wait-state count.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                lat_cnt[d] = 0;
                chk("rsp_in_reset", d, 64'(rsp[d]), 64'd0);
            end else if (req[d][0] && rsp[d][0]) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (d == 2 && q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
                if (!have) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ready dut%0d: got ready=1 required no response", d);
                end else begin
                    chk("rsp_data_err", d, {31'd0, rsp[d][RSW-1:2], rsp[d][1]}, {31'd0, e.rdata, e.err});
                    chk("latency", d, 64'(lat_cnt[d]), 64'(lat_of(d)));
                end
                lat_cnt[d] = 0;
            end else if (req[d][0]) begin
                lat_cnt[d]++;
            end else begin
                lat_cnt[d] = 0;
                chk("idle_rsp", d, 64'(rsp[d]), 64'd0);
            end
        end
    end

    task automatic xfer(input int d, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [31:0] erd, input logic eerr);
        exp_t e;
        bit   done;
        e.rdata = erd;
        e.err   = eerr;
        done    = 1'b0;
        if (d == 0) q0.push_back(e);
        if (d == 1) q1.push_back(e);
        if (d == 2) q3.push_back(e);
        req[d] = {addr, wr, wdata, strb, 1'b1};
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (rsp[d][0]) done = 1'b1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout dut%0d addr %h: got no ready required ready within 20 cycles", d, addr);
            if (d == 0 && q0.size() > 0) void'(q0.pop_back());
            if (d == 1 && q1.size() > 0) void'(q1.pop_back());
            if (d == 2 && q3.size() > 0) void'(q3.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        req[d] = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int start;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            req[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        idle(1, 2);

        // Latency 1: defaults, byte strobes, empty write, decode errors.
        xfer(1, 32'h00, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1, 32'h0C, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        xfer(1, 32'h0C, 1'b1, 32'h11223344, 4'h5, 32'h0, 1'b0);
        xfer(1, 32'h0C, 1'b0, 32'h0, 4'h0, 32'hDE22BE44, 1'b0);
        xfer(1, 32'h08, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        xfer(1, 32'h08, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(1, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(1, 32'h06, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(1, 32'h40, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        xfer(1, 32'h3C, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        xfer(1, 32'h3C, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 16; i++) scan_exp[i] = 32'h0;
        scan_exp[3]  = 32'hDE22BE44;
        scan_exp[15] = 32'hCAFEF00D;
        for (int i = 0; i < 16; i++) xfer(1, 32'(i * 4), 1'b0, 32'h0, 4'h0, scan_exp[i], 1'b0);
        idle(1, 2);

        // Latency 3: timing, dropped valid, reset mid-wait.
        xfer(2, 32'h10, 1'b1, 32'h12345678, 4'hF, 32'h0, 1'b0);
        idle(2, 1);
        req[2] = {32'h10, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b1};
        @(posedge clk);
        #1;
        idle(2, 5);
        xfer(2, 32'h10, 1'b0, 32'h0, 4'h0, 32'h12345678, 1'b0);
        xfer(2, 32'h04, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
        xfer(2, 32'h04, 1'b0, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
        req[2] = {32'h04, 1'b1, 32'h00000000, 4'hF, 1'b1};
        @(posedge clk);
        #1;
        rst[2] = 1'b1;
        req[2] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst[2] = 1'b0;
        idle(2, 2);
        xfer(2, 32'h04, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        xfer(2, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        idle(2, 2);

        // Latency 0 with BaseAddr 0x100: one transfer per cycle, base-relative bounds.
        start = cyc;
        xfer(0, 32'h100, 1'b1, 32'h11111111, 4'hF, 32'h0, 1'b0);
        xfer(0, 32'h104, 1'b1, 32'h22222222, 4'hF, 32'h0, 1'b0);
        xfer(0, 32'h108, 1'b1, 32'h33333333, 4'hF, 32'h0, 1'b0);
        xfer(0, 32'h13C, 1'b1, 32'h44444444, 4'hF, 32'h0, 1'b0);
        chk("b2b_cycles", 0, 64'(cyc - start), 64'd4);
        xfer(0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h11111111, 1'b0);
        xfer(0, 32'h104, 1'b0, 32'h0, 4'h0, 32'h22222222, 1'b0);
        xfer(0, 32'h108, 1'b0, 32'h0, 4'h0, 32'h33333333, 1'b0);
        xfer(0, 32'h13C, 1'b0, 32'h0, 4'h0, 32'h44444444, 1'b0);
        xfer(0, 32'h0FC, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(0, 32'h140, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        xfer(0, 32'h102, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        xfer(0, 32'h100, 1'b0, 32'h0, 4'h0, 32'h11111111, 1'b0);
        idle(0, 3);

        chk("sb_drained", 0, 64'(q0.size() + q1.size() + q3.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
